image_capture_param: RTL and testbench
======================================

// Module: image_capture_param
// PURPOSE
//  Parametrised OV7670-style DVP capture core; successor of the fixed RGB565->RGB444 capture.
//  Assembles 2-byte pixels, converts to OUT_W-bit format, optionally 2x2-decimates, writes frame buffer.
//  Tracks x/y position and flags address overflow and odd-length lines; pulses frame_done at end of frame.
//  Sits between the camera pins (pclk domain) and the frame-buffer BRAM write port.
// PARAMETERS
//  ADDR_W  17   frame-buffer address width
//  OUT_W   12   output pixel width: 16 (RGB565), 12 (RGB444) or 8 (RGB332)
//  H_ACT   640  camera bytes-pairs (pixels) per line expected
//  V_ACT   480  lines per frame expected
//  DECIM   1    0 = full resolution; 1 = keep only pixels with x even AND y even
// PORTS
//  pclk       in   1       camera pixel clock; sole clock
//  rst_n      in   1       asynchronous active-low reset
//  vsync      in   1       frame sync, high = vertical blank
//  href       in   1       line valid, high = active bytes on d
//  d          in   8       camera data byte, first byte of pixel = high byte of RGB565
//  cap_en     in   1       capture enable, sampled at frame start only
//  addr       out  ADDR_W  write address
//  dout       out  OUT_W   write data
//  we         out  1       write strobe, one pclk per pixel written
//  frame_done out  1       1-cycle pulse at end of a captured frame
//  busy       out  1       high in S_ACTIVE
//  ovf        out  1       sticky: write attempted beyond MAX_ADDR this frame
//  line_err   out  1       sticky: line ended with odd byte count this frame
//  frame_cnt  out  16      captured-frame counter (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst_n=0, async): all outputs 0, x=y=0, byte phase=0, state S_SYNC.
//  MAX_ADDR = (DECIM ? (H_ACT/2)*(V_ACT/2) : H_ACT*V_ACT) - 1.
//  States:
//   S_SYNC   : discard partial frame after reset; vsync=1 -> S_VBLANK.
//   S_VBLANK : addr,x,y,phase cleared; ovf,line_err cleared on entry.
//              vsync 1->0 with cap_en=1 -> S_ACTIVE; with cap_en=0 -> S_SKIP.
//   S_SKIP   : no writes; vsync=1 -> S_VBLANK.
//   S_ACTIVE : href=1: phase toggles each pclk; phase0 latches d as hi byte; phase1 forms pixel.
//              href 1->0: x=0, y++ ; phase=1 at that point -> line_err=1, phase forced 0.
//              vsync=1 -> frame_done=1 for one cycle, frame_cnt++, -> S_VBLANK.
//  Pixel on phase1: p565={hi,d}; x++ after use.
//   OUT_W16: p565; OUT_W12: {p[15:12],p[10:7],p[4:1]}; OUT_W8: {p[15:13],p[10:8],p[4:3]}.
//  Write: if kept (DECIM=0, or x[0]==0 && y[0]==0) -> dout,we=1 one cycle after phase1 byte (latency 1).
//  addr = value used with we; increments after each write. addr never exceeds MAX_ADDR:
//   kept pixel when last write was at MAX_ADDR -> we=0, ovf=1, addr holds.
//  x saturates at H_ACT (no wrap); y saturates at V_ACT.
//  href=1 during vsync=1 ignored. cap_en change mid-frame has no effect until next frame.
//  Simultaneous href fall and vsync rise: line end processed, then frame end, same cycle.
//  dout holds last written value when we=0.
// CONFIGURATION
//  CAP_FRAME_CNT_EN defined: frame_cnt counts frame_done pulses, 16-bit wrap 0xFFFF->0.
//  CAP_FRAME_CNT_EN undefined: frame_cnt tied to 16'h0, no counter logic.
// TESTING (bench params H_ACT=4, V_ACT=2, ADDR_W=4)
//  DECIM=0,OUT_W=12, frame bytes F8,00 / 07,E0 / 00,1F / FF,FF per line x2 lines
//   -> we pulses 8, dout F00,0F0,00F,FFF per line, addr 0..7, frame_done once.
//  DECIM=1 same frame -> 2 writes (line 0 pixels 0,2): dout F00,00F, addr 0,1.
//  OUT_W=16, 3-line frame (12 pixels) -> 8 writes, ovf=1, addr stays 7; cleared next vblank.
//  Line with 7 bytes -> line_err=1, next line pixels still aligned, 3 pixels written that line.
//  cap_en=0 at vsync fall -> no we, no frame_done; cap_en=1 next frame -> normal capture.
//  rst_n low mid-line -> outputs 0 immediately; partial frame skipped; next full frame captured.

Source files
------------

// File: rtl/image_capture_param.sv
// image_capture_param: DVP camera capture, 2-byte pixels to OUT_W-bit frame buffer.
// Optional frame counter enabled by defining CAP_FRAME_CNT_EN.
module image_capture_param #(
    parameter int ADDR_W = 17,
    parameter int OUT_W  = 12,
    parameter int H_ACT  = 640,
    parameter int V_ACT  = 480,
    parameter int DECIM  = 1
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        d,
    input  logic              cap_en,
    output logic [ADDR_W-1:0] addr,
    output logic [OUT_W-1:0]  dout,
    output logic              we,
    output logic              frame_done,
    output logic              busy,
    output logic              ovf,
    output logic              line_err,
    output logic [15:0]       frame_cnt
);

    localparam int XW   = $clog2(H_ACT + 1);
    localparam int YW   = $clog2(V_ACT + 1);
    localparam int NPIX = (DECIM != 0) ? (H_ACT / 2) * (V_ACT / 2)
                                       : H_ACT * V_ACT;
    localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(NPIX - 1);

    typedef enum logic [1:0] {
        S_SYNC,
        S_VBLANK,
        S_SKIP,
        S_ACTIVE
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic              phase;
    logic [7:0]        hi;
    logic              href_q;
    logic [ADDR_W-1:0] waddr;
    logic              full;
    logic [15:0]       p565;
    logic [OUT_W-1:0]  pix_cv;
    logic              keep;
    logic              byte_ok;
    logic              line_end;
    logic              unused_bits;

    assign p565     = {hi, d};
    assign keep     = (DECIM == 0) || (!x[0] && !y[0]);
    assign byte_ok  = (state == S_ACTIVE) && href && !vsync;
    assign line_end = (state == S_ACTIVE) && href_q && !href;
    assign busy     = (state == S_ACTIVE);

    generate
        if (OUT_W == 16) begin : g_565
            assign pix_cv = p565;
        end else if (OUT_W == 12) begin : g_444
            assign pix_cv = {p565[15:12], p565[10:7], p565[4:1]};
        end else begin : g_332
            assign pix_cv = {p565[15:13], p565[10:8], p565[4:3]};
        end
    endgenerate

    assign unused_bits = ^p565;

    // State register
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) state <= S_SYNC;
        else        state <= state_n;
    end

    // Next-state decode; cap_en only matters at the vblank exit
    always_comb begin
        state_n = state;
        unique case (state)
            S_SYNC:   if (vsync)  state_n = S_VBLANK;
            S_VBLANK: if (!vsync) state_n = cap_en ? S_ACTIVE : S_SKIP;
            S_SKIP:   if (vsync)  state_n = S_VBLANK;
            S_ACTIVE: if (vsync)  state_n = S_VBLANK;
            default:              state_n = S_SYNC;
        endcase
    end

    // Byte pairing, position tracking, frame-buffer writes and flags
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            addr       <= '0;
            dout       <= '0;
            we         <= 1'b0;
            frame_done <= 1'b0;
            ovf        <= 1'b0;
            line_err   <= 1'b0;
            x          <= '0;
            y          <= '0;
            phase      <= 1'b0;
            hi         <= '0;
            href_q     <= 1'b0;
            waddr      <= '0;
            full       <= 1'b0;
        end else begin
            we         <= 1'b0;
            frame_done <= 1'b0;
            href_q     <= href & ~vsync;
            if (state == S_VBLANK) begin
                addr     <= '0;
                waddr    <= '0;
                full     <= 1'b0;
                x        <= '0;
                y        <= '0;
                phase    <= 1'b0;
                ovf      <= 1'b0;
                line_err <= 1'b0;
            end
            if (byte_ok) begin
                phase <= ~phase;
                if (!phase) begin
                    hi <= d;
                end else begin
                    if (x != XW'(H_ACT)) x <= x + 1'b1;
                    if (keep) begin
                        if (full) begin
                            ovf <= 1'b1;
                        end else begin
                            we   <= 1'b1;
                            dout <= pix_cv;
                            addr <= waddr;
                            if (waddr == MAX_ADDR) full  <= 1'b1;
                            else                   waddr <= waddr + 1'b1;
                        end
                    end
                end
            end
            if (line_end) begin
                x <= '0;
                if (y != YW'(V_ACT)) y <= y + 1'b1;
                if (phase) begin
                    line_err <= 1'b1;
                    phase    <= 1'b0;
                end
            end
            if ((state == S_ACTIVE) && vsync) frame_done <= 1'b1;
        end
    end

`ifdef CAP_FRAME_CNT_EN
    // Count completed captured frames, wrapping at 16 bits
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n)                           frame_cnt <= '0;
        else if ((state == S_ACTIVE) && vsync) frame_cnt <= frame_cnt + 16'd1;
    end
`else
    assign frame_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_image_capture_param.sv
// tb_image_capture_param: directed DVP frames into three capture configurations.
// Frame counter expectations follow CAP_FRAME_CNT_EN.
module tb_image_capture_param;

`ifdef CAP_FRAME_CNT_EN
    localparam int FCEN = 1;
`else
    localparam int FCEN = 0;
`endif

    logic        pclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vsync = 1'b0;
    logic        href = 1'b0;
    logic        cap_en = 1'b1;
    logic [7:0]  d = 8'h00;

    logic [3:0]  addr0, addr1, addr2;
    logic [11:0] dout0, dout1;
    logic [15:0] dout2;
    logic        we0, we1, we2;
    logic        fd0, fd1, fd2;
    logic        busy0, busy1, busy2;
    logic        ovf0, ovf1, ovf2;
    logic        le0, le1, le2;
    logic [15:0] fc0, fc1, fc2;

    logic [19:0] q0[$];
    logic [19:0] q1[$];
    logic [19:0] q2[$];
    int          n_fd0, n_fd1, n_fd2;
    int          n_chk = 0;
    int          n_err = 0;

    logic [7:0]  pat [8] = '{8'hF8, 8'h00, 8'h07, 8'hE0,
                             8'h00, 8'h1F, 8'hFF, 8'hFF};
    logic [11:0] e12 [4] = '{12'hF00, 12'h0F0, 12'h00F, 12'hFFF};
    logic [15:0] e16 [4] = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFFF};

    image_capture_param #(.ADDR_W(4), .OUT_W(12), .H_ACT(4), .V_ACT(2), .DECIM(0)) u0 (
        .pclk(pclk), .rst_n(rst_n), .vsync(vsync), .href(href), .d(d),
        .cap_en(cap_en), .addr(addr0), .dout(dout0), .we(we0),
        .frame_done(fd0), .busy(busy0), .ovf(ovf0), .line_err(le0),
        .frame_cnt(fc0));

    image_capture_param #(.ADDR_W(4), .OUT_W(12), .H_ACT(4), .V_ACT(2), .DECIM(1)) u1 (
        .pclk(pclk), .rst_n(rst_n), .vsync(vsync), .href(href), .d(d),
        .cap_en(cap_en), .addr(addr1), .dout(dout1), .we(we1),
        .frame_done(fd1), .busy(busy1), .ovf(ovf1), .line_err(le1),
        .frame_cnt(fc1));

    image_capture_param #(.ADDR_W(4), .OUT_W(16), .H_ACT(4), .V_ACT(2), .DECIM(0)) u2 (
        .pclk(pclk), .rst_n(rst_n), .vsync(vsync), .href(href), .d(d),
        .cap_en(cap_en), .addr(addr2), .dout(dout2), .we(we2),
        .frame_done(fd2), .busy(busy2), .ovf(ovf2), .line_err(le2),
        .frame_cnt(fc2));

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] at(input logic [19:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 20'hFFFFF;
    endfunction

    task automatic drive(input logic v, input logic h, input logic [7:0] b);
        vsync = v;
        href  = h;
        d     = b;
        @(posedge pclk);
        #1;
        if (we0) q0.push_back({addr0, 4'h0, dout0});
        if (we1) q1.push_back({addr1, 4'h0, dout1});
        if (we2) q2.push_back({addr2, dout2});
        if (fd0) n_fd0++;
        if (fd1) n_fd1++;
        if (fd2) n_fd2++;
    endtask

    task automatic clr();
        q0.delete();
        q1.delete();
        q2.delete();
        n_fd0 = 0;
        n_fd1 = 0;
        n_fd2 = 0;
    endtask

    task automatic vstart();
        clr();
        repeat (3) drive(1'b1, 1'b0, 8'h00);
        repeat (2) drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic vend();
        repeat (4) drive(1'b1, 1'b0, 8'h00);
    endtask

    task automatic send_line(input int nb);
        for (int b = 0; b < nb; b++) drive(1'b0, 1'b1, pat[b % 8]);
        repeat (2) drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic chk_full12(input string tag);
        check({tag, "_n"}, q0.size(), 8);
        for (int i = 0; i < 8; i++)
            check($sformatf("%s_px%0d", tag, i), at(q0, i),
                  {4'(i), 4'h0, e12[i % 4]});
        check({tag, "_fd"}, n_fd0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        #2;
        check("rst_u0", {we0, fd0, busy0, ovf0, le0, addr0, dout0}, 0);
        check("rst_u2", {we2, fd2, busy2, ovf2, le2, addr2, dout2}, 0);
        check("rst_fc", fc0, 0);
        repeat (2) @(posedge pclk);
        #1;
        rst_n = 1'b1;

        for (int b = 0; b < 8; b++) drive(1'b0, 1'b1, pat[b]);
        drive(1'b0, 1'b0, 8'h00);
        check("sync_nowr", q0.size() + q1.size() + q2.size(), 0);

        vstart();
        check("f1_busy", busy0, 1);
        send_line(8);
        send_line(8);
        check("f1_ovf", {ovf0, ovf1, ovf2}, 0);
        vend();
        chk_full12("f1_u0");
        check("f1_u1_n", q1.size(), 2);
        check("f1_u1_a", at(q1, 0), {4'd0, 4'h0, 12'hF00});
        check("f1_u1_b", at(q1, 1), {4'd1, 4'h0, 12'h00F});
        check("f1_u2_n", q2.size(), 8);
        for (int i = 0; i < 8; i++)
            check($sformatf("f1_u2_px%0d", i), at(q2, i), {4'(i), e16[i % 4]});
        check("f1_fc", fc0, 1 * FCEN);
        check("f1_dout_hold", dout0, 12'hFFF);

        vstart();
        repeat (3) send_line(8);
        check("f2_ovf", {ovf0, ovf1, ovf2}, 3'b111);
        check("f2_addr", addr2, 7);
        vend();
        check("f2_u2_n", q2.size(), 8);
        check("f2_u2_last", at(q2, 7), {4'd7, 16'hFFFF});
        check("f2_u1_n", q1.size(), 2);
        check("f2_ovf_clr", {ovf0, ovf1, ovf2}, 0);

        vstart();
        send_line(7);
        check("f3_le", {le0, le1, le2}, 3'b111);
        send_line(8);
        vend();
        check("f3_n", q0.size(), 7);
        for (int i = 0; i < 7; i++)
            check($sformatf("f3_px%0d", i), at(q0, i),
                  {4'(i), 4'h0, (i < 3) ? e12[i] : e12[i - 3]});
        check("f3_u1_n", q1.size(), 2);
        check("f3_le_clr", {le0, le1, le2}, 0);

        cap_en = 1'b0;
        vstart();
        send_line(8);
        check("f4_busy", busy0, 0);
        send_line(8);
        vend();
        check("f4_nowr", q0.size() + q1.size() + q2.size(), 0);
        check("f4_nofd", n_fd0 + n_fd1 + n_fd2, 0);

        cap_en = 1'b1;
        vstart();
        send_line(8);
        cap_en = 1'b0;
        send_line(8);
        vend();
        cap_en = 1'b1;
        chk_full12("f5_u0");
        check("f5_fc", fc0, 4 * FCEN);

        vstart();
        drive(1'b0, 1'b1, 8'hF8);
        drive(1'b0, 1'b1, 8'h00);
        check("f6_pre_we", we0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("f6_rst_now", {we0, busy0, ovf0, le0, fd0, addr0, dout0}, 0);
        clr();
        drive(1'b0, 1'b1, 8'h07);
        rst_n = 1'b1;
        for (int b = 3; b < 8; b++) drive(1'b0, 1'b1, pat[b]);
        repeat (2) drive(1'b0, 1'b0, 8'h00);
        send_line(8);
        vend();
        check("f6_part_nowr", q0.size(), 0);
        check("f6_part_nofd", n_fd0, 0);
        vstart();
        send_line(8);
        send_line(8);
        vend();
        chk_full12("f6_u0");
        check("f6_fc", fc0, 1 * FCEN);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
